daq_event_framer: RTL and testbench

DAQ_EVENT_FRAMER -- requirements
Module: daq_event_framer

---
 rtl/daq_event_framer.sv | 210 +++++++++++++++++++++
 tb/tb_daq_event_framer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/daq_event_framer.sv
// daq_event_framer
//   Frames triggered DAQ events onto a 32-bit link with K-character flags.
//   Each l1a (while enabled) queues its bx_id; the framer then emits
//   SOE, header, payload, trailer, EOE for every queued trigger, in order.
//
// Optional feature (compile-time macro):
//   DAQ_FRAMER_CHECKSUM_EN - when defined, the trailer carries a 16-bit sum
//   of both payload half-words over the emitted payload. When undefined the
//   checksum field is zero and no adder is built.
//
// Parameters:
//   MAX_WORDS  - payload words kept per event; extra words are discarded
//   TRIG_DEPTH - trigger queue depth, power of two, at least 2
//
// Ports:
//   clk_link        in   link clock
//   reset_n         in   asynchronous active-low reset
//   enable          in   accept new triggers
//   l1a             in   trigger pulse, one trigger per high cycle
//   bx_id[11:0]     in   bunch id captured with l1a
//   frag_data[31:0] in   payload word
//   frag_valid      in   payload word valid
//   frag_last       in   final payload word of the event
//   frag_ready      out  high only while collecting payload
//   link_data[31:0] out  framed stream (registered)
//   link_is_k[3:0]  out  per-byte K-character flags (registered)
//   link_valid      out  link word meaningful (registered)
//   evt_count[23:0] out  headers emitted
//   trig_drop_count[15:0] out  triggers lost to a full queue (saturating)

module daq_event_framer #(
    parameter int MAX_WORDS  = 1020,
    parameter int TRIG_DEPTH = 4
) (
    input  logic        clk_link,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        l1a,
    input  logic [11:0] bx_id,
    input  logic [31:0] frag_data,
    input  logic        frag_valid,
    input  logic        frag_last,
    output logic        frag_ready,
    output logic [31:0] link_data,
    output logic [3:0]  link_is_k,
    output logic        link_valid,
    output logic [23:0] evt_count,
    output logic [15:0] trig_drop_count
);

    localparam int          AW        = $clog2(TRIG_DEPTH);
    localparam logic [10:0] MAX_LEN   = 11'(MAX_WORDS);
    localparam logic [31:0] IDLE_WORD = 32'h0000_00BC;
    localparam logic [31:0] SOE_WORD  = 32'h0000_003C;
    localparam logic [31:0] EOE_WORD  = 32'h0000_00DC;

    typedef enum logic [2:0] {
        S_IDLE, S_SOE, S_HDR, S_PAY, S_TRL, S_EOE
    } state_t;

    state_t state_reg, state_next;

    // ---------------- trigger queue ----------------
    logic [11:0] trig_mem [TRIG_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic        q_empty, q_full, push, pop, drop;
    logic [11:0] head_bx;
    logic [15:0] drop_cnt_reg;

    assign q_empty = (wr_ptr_reg == rd_ptr_reg);
    assign q_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // The head is consumed while the header is being built.
    assign pop     = (state_reg == S_HDR);
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign push    = l1a && enable && (!q_full || pop);
    assign drop    = l1a && enable && q_full && !pop;
    assign head_bx = trig_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk_link) begin
        if (push) begin
            trig_mem[wr_ptr_reg[AW-1:0]] <= bx_id;
        end
    end

    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            if (drop && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    // ---------------- framer ----------------
    logic [31:0] link_data_reg, link_data_next;
    logic [3:0]  link_is_k_reg, link_is_k_next;
    logic        link_valid_reg, link_valid_next;
    logic [10:0] len_reg, len_next;
    logic        trunc_reg, trunc_next;
    logic [23:0] evt_num_reg, evt_num_next;
    logic        emit;
    logic [15:0] csum_val;

`ifdef DAQ_FRAMER_CHECKSUM_EN
    logic [15:0] csum_reg;
    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            csum_reg <= '0;
        end else if (state_reg == S_HDR) begin
            csum_reg <= '0;
        end else if (emit) begin
            csum_reg <= csum_reg + frag_data[31:16] + frag_data[15:0];
        end
    end
    assign csum_val = csum_reg;
`else
    assign csum_val = 16'h0000;
`endif

    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            link_data_reg  <= IDLE_WORD;
            link_is_k_reg  <= 4'b0001;
            link_valid_reg <= 1'b0;
            len_reg        <= '0;
            trunc_reg      <= 1'b0;
            evt_num_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            link_data_reg  <= link_data_next;
            link_is_k_reg  <= link_is_k_next;
            link_valid_reg <= link_valid_next;
            len_reg        <= len_next;
            trunc_reg      <= trunc_next;
            evt_num_reg    <= evt_num_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        link_data_next  = IDLE_WORD;
        link_is_k_next  = 4'b0001;
        link_valid_next = 1'b0;
        len_next        = len_reg;
        trunc_next      = trunc_reg;
        evt_num_next    = evt_num_reg;
        emit            = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!q_empty) state_next = S_SOE;
            end
            S_SOE: begin
                link_data_next  = SOE_WORD;
                link_valid_next = 1'b1;
                state_next      = S_HDR;
            end
            S_HDR: begin
                link_data_next  = {8'hA5, evt_num_reg[11:0], head_bx};
                link_is_k_next  = 4'b0000;
                link_valid_next = 1'b1;
                evt_num_next    = evt_num_reg + 24'd1;
                len_next        = '0;
                trunc_next      = 1'b0;
                state_next      = S_PAY;
            end
            S_PAY: begin
                // Idle cycles (no valid, or discarded words) leave the IDLE default.
                if (frag_valid) begin
                    if (len_reg < MAX_LEN) begin
                        emit            = 1'b1;
                        link_data_next  = frag_data;
                        link_is_k_next  = 4'b0000;
                        link_valid_next = 1'b1;
                        len_next        = len_reg + 11'd1;
                    end else begin
                        trunc_next = 1'b1;
                    end
                    if (frag_last) state_next = S_TRL;
                end
            end
            S_TRL: begin
                link_data_next  = {csum_val, trunc_reg, 4'h0, len_reg};
                link_is_k_next  = 4'b0000;
                link_valid_next = 1'b1;
                state_next      = S_EOE;
            end
            S_EOE: begin
                link_data_next  = EOE_WORD;
                link_valid_next = 1'b1;
                state_next      = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign frag_ready      = (state_reg == S_PAY);
    assign link_data       = link_data_reg;
    assign link_is_k       = link_is_k_reg;
    assign link_valid      = link_valid_reg;
    assign evt_count       = evt_num_reg;
    assign trig_drop_count = drop_cnt_reg;

endmodule

// File: tb/tb_daq_event_framer.sv
// Directed bench for daq_event_framer (MAX_WORDS=8, TRIG_DEPTH=4).
// Expected link words are hand-computed; the checksum field follows the
// DAQ_FRAMER_CHECKSUM_EN macro of the build.

module tb_daq_event_framer;

`ifdef DAQ_FRAMER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk_link = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        l1a;
    logic [11:0] bx_id;
    logic [31:0] frag_data;
    logic        frag_valid;
    logic        frag_last;
    logic        frag_ready;
    logic [31:0] link_data;
    logic [3:0]  link_is_k;
    logic        link_valid;
    logic [23:0] evt_count;
    logic [15:0] trig_drop_count;

    int n_cmp = 0;
    int n_err = 0;

    daq_event_framer #(.MAX_WORDS(8), .TRIG_DEPTH(4)) dut (
        .clk_link        (clk_link),
        .reset_n         (reset_n),
        .enable          (enable),
        .l1a             (l1a),
        .bx_id           (bx_id),
        .frag_data       (frag_data),
        .frag_valid      (frag_valid),
        .frag_last       (frag_last),
        .frag_ready      (frag_ready),
        .link_data       (link_data),
        .link_is_k       (link_is_k),
        .link_valid      (link_valid),
        .evt_count       (evt_count),
        .trig_drop_count (trig_drop_count)
    );

    always #5 clk_link = ~clk_link;

    task automatic tick();
        @(posedge clk_link);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_link(input string tag, input logic [31:0] d, input logic [3:0] k, input logic v);
        chk(tag, {3'b0, link_data, link_is_k, link_valid}, {3'b0, d, k, v});
    endtask

    function automatic logic [31:0] trl(input logic [15:0] cs, input logic tr, input logic [10:0] len);
        return {(CSUM_ON ? cs : 16'h0000), tr, 4'h0, len};
    endfunction

    // Bounded wait for the next header word, then compare it.
    task automatic wait_hdr(input string tag, input logic [31:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (link_valid === 1'b1 && link_is_k === 4'b0000) seen = 1'b1;
        end
        chk({tag, "_seen"}, {39'b0, seen}, 40'd1);
        if (seen) chk_link(tag, exp, 4'b0000, 1'b1);
    endtask

    task automatic pay(input string tag, input logic [31:0] d, input logic last, input logic exp_emit);
        frag_valid = 1'b1;
        frag_data  = d;
        frag_last  = last;
        tick();
        frag_valid = 1'b0;
        frag_last  = 1'b0;
        if (exp_emit) chk_link(tag, d, 4'b0000, 1'b1);
        else          chk_link(tag, 32'h0000_00BC, 4'b0001, 1'b0);
    endtask

    task automatic end_evt(input string tag, input logic [31:0] exp_trl);
        tick();
        chk_link({tag, "_trl"}, exp_trl, 4'b0000, 1'b1);
        tick();
        chk_link({tag, "_eoe"}, 32'h0000_00DC, 4'b0001, 1'b1);
    endtask

    task automatic trigger(input logic [11:0] bx);
        l1a   = 1'b1;
        bx_id = bx;
        tick();
        l1a   = 1'b0;
    endtask

    initial begin
        bit any_valid;
        reset_n = 1'b0; enable = 1'b0; l1a = 1'b0; bx_id = '0;
        frag_data = '0; frag_valid = 1'b0; frag_last = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        chk_link("rst_link", 32'h0000_00BC, 4'b0001, 1'b0);
        chk("rst_ready", {39'b0, frag_ready}, 40'd0);
        chk("rst_evt", {16'b0, evt_count}, 40'd0);
        chk("rst_drop", {24'b0, trig_drop_count}, 40'd0);
        reset_n = 1'b1;
        tick();

        // ---- basic event, exact latency ----
        enable = 1'b1;
        trigger(12'h123);
        chk_link("bas_idle0", 32'h0000_00BC, 4'b0001, 1'b0);
        tick();
        chk_link("bas_idle1", 32'h0000_00BC, 4'b0001, 1'b0);
        tick();
        chk_link("bas_soe", 32'h0000_003C, 4'b0001, 1'b1);
        tick();
        chk_link("bas_hdr", 32'hA500_0123, 4'b0000, 1'b1);
        chk("bas_ready", {39'b0, frag_ready}, 40'd1);
        chk("bas_evt", {16'b0, evt_count}, 40'd1);
        pay("bas_w1", 32'd1, 1'b0, 1'b1);
        pay("bas_w2", 32'd2, 1'b0, 1'b1);
        pay("bas_w3", 32'd3, 1'b1, 1'b1);
        end_evt("bas", trl(16'h0006, 1'b0, 11'd3));
        tick();
        chk_link("bas_post", 32'h0000_00BC, 4'b0001, 1'b0);
        chk("bas_rdy0", {39'b0, frag_ready}, 40'd0);

        // ---- trigger overflow: six pulses while parked in payload ----
        trigger(12'h200);
        wait_hdr("ovf_hdr", 32'hA500_1200);
        for (int i = 0; i < 6; i++) begin
            l1a   = 1'b1;
            bx_id = 12'(12'h210 + i);
            tick();
            chk_link("ovf_gap", 32'h0000_00BC, 4'b0001, 1'b0);
        end
        l1a = 1'b0;
        chk("ovf_drop", {24'b0, trig_drop_count}, 40'd2);
        pay("ovf_w1", 32'h0000_0007, 1'b1, 1'b1);
        end_evt("ovf", trl(16'h0007, 1'b0, 11'd1));
        for (int k = 0; k < 4; k++) begin
            wait_hdr("ovf_q_hdr", {8'hA5, 12'(2 + k), 12'(12'h210 + k)});
            pay("ovf_q_w", 32'h0000_0001, 1'b1, 1'b1);
            end_evt("ovf_q", trl(16'h0001, 1'b0, 11'd1));
        end
        any_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (link_valid !== 1'b0) any_valid = 1'b1;
        end
        chk("ovf_drained", {39'b0, any_valid}, 40'd0);
        chk("ovf_evt", {16'b0, evt_count}, 40'd6);
        chk("ovf_drop2", {24'b0, trig_drop_count}, 40'd2);

        // ---- truncation: 12 words, 8 kept ----
        trigger(12'h300);
        wait_hdr("trc_hdr", 32'hA500_6300);
        for (int i = 1; i <= 12; i++) begin
            chk("trc_ready", {39'b0, frag_ready}, 40'd1);
            pay("trc_w", 32'h0001_0000 + 32'(i), (i == 12), (i <= 8));
        end
        end_evt("trc", trl(16'h002C, 1'b1, 11'd8));

        // ---- payload gap ----
        trigger(12'h400);
        wait_hdr("gap_hdr", 32'hA500_7400);
        pay("gap_w1", 32'h0000_0010, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_link("gap_idle", 32'h0000_00BC, 4'b0001, 1'b0);
        end
        pay("gap_w2", 32'h0000_0020, 1'b1, 1'b1);
        end_evt("gap", trl(16'h0030, 1'b0, 11'd2));
        chk("gap_evt", {16'b0, evt_count}, 40'd8);

        // ---- mid-event reset ----
        trigger(12'h500);
        wait_hdr("mrs_hdr", 32'hA500_8500);
        pay("mrs_w1", 32'h0000_0001, 1'b0, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_link("mrs_link", 32'h0000_00BC, 4'b0001, 1'b0);
        chk("mrs_ready", {39'b0, frag_ready}, 40'd0);
        chk("mrs_evt", {16'b0, evt_count}, 40'd0);
        chk("mrs_drop", {24'b0, trig_drop_count}, 40'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk_link("mrs_noeoe", 32'h0000_00BC, 4'b0001, 1'b0);
        trigger(12'h600);
        wait_hdr("mrs_hdr2", 32'hA500_0600);
        pay("mrs_w2", 32'h0000_0005, 1'b1, 1'b1);
        end_evt("mrs", trl(16'h0005, 1'b0, 11'd1));

        // ---- disable with one trigger queued ----
        trigger(12'h700);
        enable = 1'b0;
        trigger(12'h701);
        wait_hdr("dis_hdr", 32'hA500_1700);
        pay("dis_w1", 32'h0000_0009, 1'b1, 1'b1);
        end_evt("dis", trl(16'h0009, 1'b0, 11'd1));
        any_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (link_valid !== 1'b0) any_valid = 1'b1;
        end
        chk("dis_nomore", {39'b0, any_valid}, 40'd0);
        chk("dis_drop", {24'b0, trig_drop_count}, 40'd0);
        chk("dis_evt", {16'b0, evt_count}, 40'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
